// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: parity modes, FSM state
// encoding and the parity-bit helper.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Parity bit for a word zero-extended to 9 bits (zero padding leaves the
  // XOR reduction unchanged). Even parity makes the total count of ones
  // even; odd parity makes it odd.
  function automatic logic parity_bit(logic [8:0] data, int mode);
    if (mode == PAR_ODD) begin
      return ~^data;
    end else if (mode == PAR_EVEN) begin
      return ^data;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a separately tracked fill level. Pushes while full
// and pops while empty are ignored, so stored data is never overwritten.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write on an accepted push.
  // NOTE: the data array has no reset; only pointers and level define
  // validity, and leaving storage unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointers wrap naturally at DEPTH; level counts push minus pop.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Serial transmitter with an input FIFO. Queued words are sent LSB-first
// with configurable framing; consecutive frames follow with no idle gap.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_BITS-1:0]          txbyte,
  input  logic                          senddata,
  output logic                          ready,
  output logic                          txdone,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int DW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(CLKS_PER_BIT - 2);
  localparam logic [DW-1:0] DATA_LAST  = DW'(DATA_BITS - 1);
  localparam logic [DW-1:0] STOP_LAST  = DW'(STOP_BITS - 1);

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [DW-1:0]          idx_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   parity_q;
  logic                   tx_q;
  logic                   txdone_q;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_pop;
  logic [DATA_BITS-1:0]   fifo_dout;
  logic                   bit_end;
  logic                   frame_end;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (senddata),
    .pop   (fifo_pop),
    .din   (txbyte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bit_end   = (cnt_q == CNT_LAST);
  assign frame_end = (state_q == ST_STOP) && bit_end && (idx_q == STOP_LAST);
  // A word is taken either from idle or straight at the end of a frame.
  assign fifo_pop  = !fifo_empty && ((state_q == ST_IDLE) || frame_end);

  assign ready  = !fifo_full;
  assign busy   = (state_q != ST_IDLE) || !fifo_empty;
  assign tx     = tx_q;
  assign txdone = txdone_q;

  // Frame sequencer: bit timing, shifting, parity and stop handling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      txdone_q <= 1'b0;
    end else begin
      txdone_q <= 1'b0;
      cnt_q    <= (state_q == ST_IDLE || bit_end) ? '0 : cnt_q + 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          tx_q <= 1'b1;
        end
        ST_START: begin
          if (bit_end) begin
            tx_q    <= shift_q[0];
            idx_q   <= '0;
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (idx_q == DATA_LAST) begin
              idx_q <= '0;
              if (PARITY != PAR_NONE) begin
                tx_q    <= parity_q;
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              idx_q   <= idx_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            tx_q    <= 1'b1;
            idx_q   <= '0;
            state_q <= ST_STOP;
          end
        end
        ST_STOP: begin
          // Pulse lands on the final cycle of the last stop bit.
          if (idx_q == STOP_LAST && cnt_q == CNT_PENULT) begin
            txdone_q <= 1'b1;
          end
          if (bit_end) begin
            if (idx_q != STOP_LAST) begin
              idx_q <= idx_q + 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Loading a word overrides the idle/stop exit above.
      if (fifo_pop) begin
        shift_q  <= fifo_dout;
        parity_q <= parity_bit(9'(fifo_dout), PARITY);
        tx_q     <= 1'b0;
        idx_q    <= '0;
        state_q  <= ST_START;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: four instances cover 8N1, 8E2, 8O1 and
// 7O1 framing; FIFO, back-to-back and reset behaviour use the 8N1 instance.
module tb_uart_tx_fifo;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tb0, tb1, tb2;
  logic [6:0] tb3;
  logic       sd0, sd1, sd2, sd3;
  logic       rdy0, rdy1, rdy2, rdy3;
  logic       dn0, dn1, dn2, dn3;
  logic       bz0, bz1, bz2, bz3;
  logic       tx0, tx1, tx2, tx3;
  logic [2:0] lv0, lv1, lv2, lv3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .clk(clk), .rst_n(rst_n), .txbyte(tb0), .senddata(sd0), .ready(rdy0),
    .txdone(dn0), .busy(bz0), .fifo_level(lv0), .tx(tx0));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .txbyte(tb1), .senddata(sd1), .ready(rdy1),
    .txdone(dn1), .busy(bz1), .fifo_level(lv1), .tx(tx1));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .txbyte(tb2), .senddata(sd2), .ready(rdy2),
    .txdone(dn2), .busy(bz2), .fifo_level(lv2), .tx(tx2));
  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u3 (
    .clk(clk), .rst_n(rst_n), .txbyte(tb3), .senddata(sd3), .ready(rdy3),
    .txdone(dn3), .busy(bz3), .fifo_level(lv3), .tx(tx3));

  function automatic logic tx_of(int i);
    case (i)
      0:       return tx0;
      1:       return tx1;
      2:       return tx2;
      default: return tx3;
    endcase
  endfunction

  function automatic logic done_of(int i);
    case (i)
      0:       return dn0;
      1:       return dn1;
      2:       return dn2;
      default: return dn3;
    endcase
  endfunction

  // Drive one push on instance i; returns just after the accepting edge.
  task automatic push_word(input int i, input logic [7:0] d);
    @(posedge clk); #1;
    case (i)
      0:       begin sd0 = 1'b1; tb0 = d; end
      1:       begin sd1 = 1'b1; tb1 = d; end
      2:       begin sd2 = 1'b1; tb2 = d; end
      default: begin sd3 = 1'b1; tb3 = d[6:0]; end
    endcase
    @(posedge clk); #1;
    sd0 = 1'b0; sd1 = 1'b0; sd2 = 1'b0; sd3 = 1'b0;
  endtask

  // Step cycles until tx of instance i is low; waited = cycles taken, -1 on timeout.
  task automatic wait_tx_low(input int i, input int budget, output int waited);
    waited = -1;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      if (tx_of(i) == 1'b0) begin
        waited = c;
        break;
      end
    end
  endtask

  // Record a frame already in progress at cycle first_k (cycle 1 = first
  // start-bit cycle): mid-bit samples, in-bit changes, txdone position/count.
  task automatic grab_frame(input int i, input int nbits, input int first_k,
                            output logic [15:0] bits, output int glitches,
                            output int done_at, output int done_cnt);
    logic r;
    r        = 1'b1;
    bits     = '0;
    glitches = 0;
    done_at  = -1;
    done_cnt = 0;
    for (int k = first_k; k <= nbits * CPB; k++) begin
      if (k > first_k) begin
        @(posedge clk); #1;
      end
      if (k == first_k || (k - 1) % CPB == 0) r = tx_of(i);
      else if (tx_of(i) !== r) glitches++;
      if ((k - 1) % CPB == CPB / 2) bits[(k - 1) / CPB] = tx_of(i);
      if (done_of(i) === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = k;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({tx0, tx1, tx2, tx3} !== 4'hF) begin n_fail++; $display("FAIL reset_tx: got %b expected 1111", {tx0, tx1, tx2, tx3}); end
    n_checks++; if ({rdy0, rdy1, rdy2, rdy3} !== 4'hF) begin n_fail++; $display("FAIL reset_ready: got %b expected 1111", {rdy0, rdy1, rdy2, rdy3}); end
    n_checks++; if ({dn0, dn1, dn2, dn3} !== 4'h0) begin n_fail++; $display("FAIL reset_txdone: got %b expected 0000", {dn0, dn1, dn2, dn3}); end
    n_checks++; if ({bz0, bz1, bz2, bz3} !== 4'h0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0000", {bz0, bz1, bz2, bz3}); end
    n_checks++; if ({lv0, lv1, lv2, lv3} !== 12'h000) begin n_fail++; $display("FAIL reset_level: got %h expected 000", {lv0, lv1, lv2, lv3}); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_8n1();
    logic [15:0] bits;
    int gl, da, dc, w;
    push_word(0, 8'hDA);
    tb0 = 8'h00;
    n_checks++; if (lv0 !== 3'd1) begin n_fail++; $display("FAIL 8n1_level: got %0d expected 1", lv0); end
    n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL 8n1_tx_at_push: got %b expected 1", tx0); end
    n_checks++; if (bz0 !== 1'b1) begin n_fail++; $display("FAIL 8n1_busy: got %b expected 1", bz0); end
    wait_tx_low(0, 20, w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL 8n1_start_latency: got %0d expected 1", w); end
    grab_frame(0, 10, 1, bits, gl, da, dc);
    n_checks++; if (bits[9:0] !== 10'b1110110100) begin n_fail++; $display("FAIL 8n1_bits: got %b expected 1110110100", bits[9:0]); end
    n_checks++; if (gl != 0) begin n_fail++; $display("FAIL 8n1_bit_stability: got %0d changes expected 0", gl); end
    n_checks++; if (da != 160) begin n_fail++; $display("FAIL 8n1_txdone_cycle: got %0d expected 160", da); end
    n_checks++; if (dc != 1) begin n_fail++; $display("FAIL 8n1_txdone_count: got %0d expected 1", dc); end
    @(posedge clk); #1;
    n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL 8n1_idle_tx: got %b expected 1", tx0); end
    n_checks++; if (bz0 !== 1'b0) begin n_fail++; $display("FAIL 8n1_idle_busy: got %b expected 0", bz0); end
  endtask

  task automatic test_parity_stop();
    logic [15:0] bits;
    int gl, da, dc, w;
    // 8E2: 0xDA has five ones, even parity bit = 1, two stop bits
    push_word(1, 8'hDA);
    wait_tx_low(1, 20, w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL 8e2_start_latency: got %0d expected 1", w); end
    grab_frame(1, 12, 1, bits, gl, da, dc);
    n_checks++; if (bits[11:0] !== 12'b111110110100) begin n_fail++; $display("FAIL 8e2_bits: got %b expected 111110110100", bits[11:0]); end
    n_checks++; if (gl != 0) begin n_fail++; $display("FAIL 8e2_bit_stability: got %0d changes expected 0", gl); end
    n_checks++; if (da != 192 || dc != 1) begin n_fail++; $display("FAIL 8e2_txdone: got cycle %0d count %0d expected cycle 192 count 1", da, dc); end
    // 8O1: odd parity bit = 0
    push_word(2, 8'hDA);
    wait_tx_low(2, 20, w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL 8o1_start_latency: got %0d expected 1", w); end
    grab_frame(2, 11, 1, bits, gl, da, dc);
    n_checks++; if (bits[10:0] !== 11'b10110110100) begin n_fail++; $display("FAIL 8o1_bits: got %b expected 10110110100", bits[10:0]); end
    n_checks++; if (gl != 0) begin n_fail++; $display("FAIL 8o1_bit_stability: got %0d changes expected 0", gl); end
    n_checks++; if (da != 176 || dc != 1) begin n_fail++; $display("FAIL 8o1_txdone: got cycle %0d count %0d expected cycle 176 count 1", da, dc); end
  endtask

  task automatic test_7bit();
    logic [15:0] bits;
    int gl, da, dc, w;
    // 7O1 with 0x41: frame 0,1,0,0,0,0,0,1,1,1
    push_word(3, 8'h41);
    wait_tx_low(3, 20, w);
    n_checks++; if (w != 1) begin n_fail++; $display("FAIL 7o1_start_latency: got %0d expected 1", w); end
    grab_frame(3, 10, 1, bits, gl, da, dc);
    n_checks++; if (bits[9:0] !== 10'b1110000010) begin n_fail++; $display("FAIL 7o1_bits: got %b expected 1110000010", bits[9:0]); end
    n_checks++; if (gl != 0) begin n_fail++; $display("FAIL 7o1_bit_stability: got %0d changes expected 0", gl); end
    n_checks++; if (da != 160 || dc != 1) begin n_fail++; $display("FAIL 7o1_txdone: got cycle %0d count %0d expected cycle 160 count 1", da, dc); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] bits;
    logic [9:0]  exp_f [3];
    int gl, da, dc;
    exp_f[0] = 10'b1010101010;  // 0x55
    exp_f[1] = 10'b1101000110;  // 0xA3
    exp_f[2] = 10'b1000011110;  // 0x0F
    @(posedge clk); #1; sd0 = 1'b1; tb0 = 8'h55;
    @(posedge clk); #1; tb0 = 8'hA3;
    n_checks++; if (lv0 !== 3'd1) begin n_fail++; $display("FAIL b2b_level_first: got %0d expected 1", lv0); end
    @(posedge clk); #1; tb0 = 8'h0F;
    // push and pop on the same edge leave the level unchanged
    n_checks++; if (lv0 !== 3'd1 || tx0 !== 1'b0) begin n_fail++; $display("FAIL b2b_push_pop: got level %0d tx %b expected level 1 tx 0", lv0, tx0); end
    @(posedge clk); #1; sd0 = 1'b0;
    n_checks++; if (lv0 !== 3'd2) begin n_fail++; $display("FAIL b2b_level_queued: got %0d expected 2", lv0); end
    for (int f = 0; f < 3; f++) begin
      if (f == 0) begin
        grab_frame(0, 10, 2, bits, gl, da, dc);
      end else begin
        @(posedge clk); #1;
        n_checks++; if (tx0 !== 1'b0) begin n_fail++; $display("FAIL b2b_gap_frame%0d: got tx %b expected 0", f, tx0); end
        grab_frame(0, 10, 1, bits, gl, da, dc);
      end
      n_checks++; if (bits[9:0] !== exp_f[f] || gl != 0) begin n_fail++; $display("FAIL b2b_bits_frame%0d: got %b changes %0d expected %b changes 0", f, bits[9:0], gl, exp_f[f]); end
      n_checks++; if (da != 160 || dc != 1) begin n_fail++; $display("FAIL b2b_txdone_frame%0d: got cycle %0d count %0d expected 160 count 1", f, da, dc); end
    end
    @(posedge clk); #1;
    n_checks++; if (tx0 !== 1'b1 || bz0 !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got tx %b busy %b expected tx 1 busy 0", tx0, bz0); end
  endtask

  task automatic test_overflow();
    logic [15:0] bits;
    logic [7:0]  words [6];
    logic [9:0]  ef;
    int gl, da, dc, w;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    words[3] = 8'h44; words[4] = 8'h55; words[5] = 8'h66;
    push_word(0, words[0]);
    @(posedge clk); #1;
    n_checks++; if (tx0 !== 1'b0) begin n_fail++; $display("FAIL ovf_first_start: got %b expected 0", tx0); end
    for (int i = 1; i < 6; i++) begin
      sd0 = 1'b1; tb0 = words[i];
      if (i == 5) begin
        n_checks++; if (rdy0 !== 1'b0 || lv0 !== 3'd4) begin n_fail++; $display("FAIL ovf_full: got ready %b level %0d expected ready 0 level 4", rdy0, lv0); end
      end
      @(posedge clk); #1;
    end
    sd0 = 1'b0;
    n_checks++; if (lv0 !== 3'd4) begin n_fail++; $display("FAIL ovf_level_after_drop: got %0d expected 4", lv0); end
    for (int f = 0; f < 5; f++) begin
      if (f == 0) begin
        grab_frame(0, 10, 6, bits, gl, da, dc);
      end else begin
        @(posedge clk); #1;
        if (f == 1) begin
          n_checks++; if (rdy0 !== 1'b1 || lv0 !== 3'd3) begin n_fail++; $display("FAIL ovf_ready_return: got ready %b level %0d expected ready 1 level 3", rdy0, lv0); end
        end
        grab_frame(0, 10, 1, bits, gl, da, dc);
      end
      ef = {1'b1, words[f], 1'b0};
      n_checks++; if (bits[9:0] !== ef || gl != 0 || da != 160 || dc != 1) begin n_fail++; $display("FAIL ovf_frame%0d: got bits %b changes %0d done %0d/%0d expected bits %b changes 0 done 160/1", f, bits[9:0], gl, da, dc, ef); end
    end
    @(posedge clk); #1;
    n_checks++; if (tx0 !== 1'b1 || bz0 !== 1'b0 || lv0 !== 3'd0) begin n_fail++; $display("FAIL ovf_end: got tx %b busy %b level %0d expected 1 0 0", tx0, bz0, lv0); end
    wait_tx_low(0, 200, w);
    n_checks++; if (w != -1) begin n_fail++; $display("FAIL ovf_extra_frame: got start after %0d cycles expected none", w); end
  endtask

  task automatic test_reset_mid_frame();
    int lows, dones;
    @(posedge clk); #1; sd0 = 1'b1; tb0 = 8'h00;
    @(posedge clk); #1; tb0 = 8'hC3;
    @(posedge clk); #1; tb0 = 8'h3C;
    @(posedge clk); #1; sd0 = 1'b0;
    n_checks++; if (lv0 !== 3'd2) begin n_fail++; $display("FAIL rst_queued_level: got %0d expected 2", lv0); end
    // cycle 2 of the frame now; advance to cycle 72, inside data bit 3
    repeat (70) begin
      @(posedge clk); #1;
    end
    n_checks++; if (tx0 !== 1'b0) begin n_fail++; $display("FAIL rst_pre_tx: got %b expected 0", tx0); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL rst_async_tx: got %b expected 1", tx0); end
    n_checks++; if (lv0 !== 3'd0 || bz0 !== 1'b0 || rdy0 !== 1'b1) begin n_fail++; $display("FAIL rst_async_state: got level %0d busy %b ready %b expected 0 0 1", lv0, bz0, rdy0); end
    lows  = 0;
    dones = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (c == 3) rst_n = 1'b1;
      if (tx0 !== 1'b1) lows++;
      if (dn0 !== 1'b0) dones++;
    end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL rst_no_frames: got %0d low cycles expected 0", lows); end
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL rst_no_txdone: got %0d pulses expected 0", dones); end
  endtask

  initial begin
    rst_n = 1'b0;
    sd0 = 1'b0; sd1 = 1'b0; sd2 = 1'b0; sd3 = 1'b0;
    tb0 = '0;   tb1 = '0;   tb2 = '0;   tb3 = '0;
    test_reset();
    test_8n1();
    test_parity_stop();
    test_7bit();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
